audio_stream_bridge: RTL and testbench
======================================

Name: audio_stream_bridge

Overview:
- Sits between the audio codec controller and the effects datapath, inside the board-level wrapper.
- Converts the controller's level-style interface (audio_in_available / read_audio_in, audio_out_allowed / write_audio_out) into valid/ready stereo streams.
- Source stream feeds the effects. Sink stream comes back from the effects and is buffered in a small FIFO before being written to the DAC.
- Counts input samples dropped because the effects stage stalled.

Parameters:
- DATA_W, 32, bits per channel word (matches controller sample width).
- FIFO_DEPTH, 4, entries in the output {L,R} FIFO; power of 2, at least 2.
- DROP_WHEN_FULL, 1, 1 = keep reading the codec while the source hold register is occupied and discard new samples; 0 = stop reading.

Ports:
- CLOCK_50  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- audio_in_available  in  1  controller has an ADC sample.
- read_audio_in  out  1  one-cycle acknowledge/pop to controller.
- left_channel_audio_in  in  DATA_W  ADC left word.
- right_channel_audio_in  in  DATA_W  ADC right word.
- audio_out_allowed  in  1  controller can accept a DAC sample.
- write_audio_out  out  1  one-cycle DAC write strobe.
- left_channel_audio_out  out  DATA_W  DAC left word.
- right_channel_audio_out  out  DATA_W  DAC right word.
- src_valid  out  1  source stream valid (to effects).
- src_ready  in  1  effects accepts source sample.
- src_L  out  DATA_W  source left.
- src_R  out  DATA_W  source right.
- snk_valid  in  1  effects output valid.
- snk_ready  out  1  bridge accepts effects output.
- snk_L  in  DATA_W  sink left.
- snk_R  in  DATA_W  sink right.
- drop_count  out  16  saturating count of discarded ADC samples.

Behaviour:

Reset:
- reset_n=0 asynchronously clears all state and all outputs to 0, including snk_ready.
- A run flag sets on the first CLOCK_50 edge after release; snk_ready = run & !fifo_full.
- Reset mid-operation discards the hold register and FIFO contents, clears drop_count, and returns both FSMs to IDLE. A pulse in flight is cut the same instant.

Input FSM (IN_IDLE, IN_WAIT):
- slot_free = !src_valid | src_ready (the held sample leaves this cycle).
- IN_IDLE with audio_in_available=1 and slot_free=1:
  - Next edge: capture left/right_channel_audio_in into src_L/src_R, set src_valid=1, assert read_audio_in=1 for exactly one cycle.
  - Go to IN_WAIT.
- IN_IDLE with audio_in_available=1, slot_free=0, DROP_WHEN_FULL=1:
  - Pulse read_audio_in one cycle without capturing.
  - drop_count+1, saturating at 0xFFFF.
  - Go to IN_WAIT.
- IN_IDLE with audio_in_available=1, slot_free=0, DROP_WHEN_FULL=0: no read; stay in IN_IDLE.
- IN_WAIT: read_audio_in=0; unconditionally go to IN_IDLE next edge. This lets the controller update its data.
- Result: at most one read per 2 cycles.
- Latency: available sampled at cycle N → read_audio_in and src_valid high at N+1.
- src handshake:
  - src_L/src_R stable while src_valid=1 and src_ready=0.
  - On src_valid & src_ready with no new capture, src_valid clears next edge.
  - Accept and capture in the same cycle gives back-to-back valid with the new data.

Output FIFO:
- Push on snk_valid & snk_ready; pop on the output FSM write.
- Push and pop in the same cycle leaves the count unchanged.
- Push is never accepted when full, because snk_ready=0; data order is preserved.
- Pointer wrap is modulo FIFO_DEPTH. An extra count bit distinguishes full from empty.

Output FSM (OUT_IDLE, OUT_WAIT):
- OUT_IDLE with FIFO non-empty and audio_out_allowed=1:
  - Next edge: register the head into left/right_channel_audio_out, assert write_audio_out=1 for exactly one cycle, pop.
  - Go to OUT_WAIT.
- OUT_WAIT: write_audio_out=0; go to OUT_IDLE next edge.
- Latency: allowed sampled at M → write at M+1; max one write per 2 cycles.
- left/right_channel_audio_out hold their last written value between writes.
- FIFO empty while allowed=1: no write (underrun is silent and not counted).

Test Plan:
1. Reset: reset_n=0 for 5 cycles with audio_in_available=1 and snk_valid=1 → every output 0; no read_audio_in; snk_ready=0; snk_ready=1 one edge after release.
2. Passthrough: L=0x00123456, R=0xFFEDCBA9, available high at N, src looped to snk, src_ready=1, audio_out_allowed=1:
   - read_audio_in pulses exactly at N+1.
   - src_valid high at N+1.
   - write_audio_out pulses with out L=0x00123456, R=0xFFEDCBA9.
   - drop_count=0.
3. Stall, DROP_WHEN_FULL=1: src_ready=0, available held high for 8 cycles:
   - First sample held with data unchanged.
   - Reads pulse every 2 cycles.
   - drop_count=3 after 3 further reads.
   - Repeat with DROP_WHEN_FULL=0 → only 1 read; drop_count=0.
4. FIFO full: audio_out_allowed=0, push 0x1..0x5 back-to-back:
   - snk_ready=0 after the 4th push; 5th stalls.
   - allowed=1 → writes 0x1,0x2,0x3,0x4,0x5 in order, 2 cycles apart.
   - 5th accepted once space frees.
5. Saturation: preload stall, force 65540 drops → drop_count=0xFFFF, stays.
6. Mid-op reset: assert reset_n=0 in the same cycle as a read pulse with 3 FIFO entries → read_audio_in and write_audio_out drop at once; after release the FIFO is empty and the first write occurs only after a new push.

Source files
------------

// File: rtl/audio_stream_bridge.sv
// audio_stream_bridge
//   Bridges the audio codec controller's level-style handshakes to
//   valid/ready stereo streams for the effects datapath.
//   - Input side: reads an ADC sample pair at most once every two cycles and
//     presents it on the src stream. If the src hold register is still
//     occupied, the sample is either discarded and counted (DROP_WHEN_FULL=1)
//     or left in the controller (DROP_WHEN_FULL=0).
//   - Output side: accepts the sink stream into a FIFO_DEPTH-entry {L,R} FIFO
//     and writes its head to the DAC at most once every two cycles.
//
// Ports
//   CLOCK_50, reset_n                  clock, asynchronous active-low reset
//   audio_in_available/read_audio_in   ADC level / one-cycle pop strobe
//   left/right_channel_audio_in        ADC sample words
//   audio_out_allowed/write_audio_out  DAC level / one-cycle write strobe
//   left/right_channel_audio_out       DAC sample words (hold between writes)
//   src_valid/src_ready/src_L/src_R    source stream to the effects
//   snk_valid/snk_ready/snk_L/snk_R    sink stream from the effects
//   drop_count                         saturating count of discarded samples
module audio_stream_bridge #(
  parameter int DATA_W         = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int DROP_WHEN_FULL = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              audio_in_available,
  output logic              read_audio_in,
  input  logic [DATA_W-1:0] left_channel_audio_in,
  input  logic [DATA_W-1:0] right_channel_audio_in,
  input  logic              audio_out_allowed,
  output logic              write_audio_out,
  output logic [DATA_W-1:0] left_channel_audio_out,
  output logic [DATA_W-1:0] right_channel_audio_out,
  output logic              src_valid,
  input  logic              src_ready,
  output logic [DATA_W-1:0] src_L,
  output logic [DATA_W-1:0] src_R,
  input  logic              snk_valid,
  output logic              snk_ready,
  input  logic [DATA_W-1:0] snk_L,
  input  logic [DATA_W-1:0] snk_R,
  output logic [15:0]       drop_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IN_IDLE, IN_WAIT}   in_state_e;
  typedef enum logic {OUT_IDLE, OUT_WAIT} out_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  in_state_e               in_state_q, in_state_d;
  out_state_e              out_state_q, out_state_d;
  logic                    run_q;
  logic                    read_q, read_d;
  logic                    src_valid_q, src_valid_d;
  logic [DATA_W-1:0]       src_l_q, src_l_d, src_r_q, src_r_d;
  logic [15:0]             drop_q, drop_d;
  logic                    wr_q, wr_d;
  logic [DATA_W-1:0]       out_l_q, out_l_d, out_r_q, out_r_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [2*DATA_W-1:0]     fifo_mem_q [FIFO_DEPTH];

  logic slot_free;
  logic fifo_full, fifo_empty;
  logic push, pop;

  // The held sample counts as free if it is being accepted this very cycle.
  assign slot_free  = !src_valid_q || src_ready;
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = snk_valid && snk_ready;
  assign pop        = (out_state_q == OUT_IDLE) && !fifo_empty && audio_out_allowed;

  // ---------------------------------------------------------------------------
  // Input FSM: ADC level interface -> src stream
  // ---------------------------------------------------------------------------
  always_comb begin
    in_state_d  = in_state_q;
    read_d      = 1'b0;
    src_valid_d = src_valid_q;
    src_l_d     = src_l_q;
    src_r_d     = src_r_q;
    drop_d      = drop_q;
    if (src_valid_q && src_ready) src_valid_d = 1'b0;
    unique case (in_state_q)
      IN_IDLE: begin
        if (audio_in_available) begin
          if (slot_free) begin
            src_valid_d = 1'b1;
            src_l_d     = left_channel_audio_in;
            src_r_d     = right_channel_audio_in;
            read_d      = 1'b1;
            in_state_d  = IN_WAIT;
          end else if (DROP_WHEN_FULL != 0) begin
            // Pop the controller anyway so the ADC never backs up.
            read_d     = 1'b1;
            drop_d     = sat_inc16(drop_q);
            in_state_d = IN_WAIT;
          end
        end
      end
      // One dead cycle lets the controller present its next sample.
      IN_WAIT: in_state_d = IN_IDLE;
      default: in_state_d = IN_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output FSM: FIFO head -> DAC level interface
  // ---------------------------------------------------------------------------
  always_comb begin
    out_state_d = out_state_q;
    wr_d        = 1'b0;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    unique case (out_state_q)
      OUT_IDLE: begin
        if (pop) begin
          wr_d        = 1'b1;
          out_l_d     = fifo_mem_q[rd_ptr_q][2*DATA_W-1:DATA_W];
          out_r_d     = fifo_mem_q[rd_ptr_q][DATA_W-1:0];
          out_state_d = OUT_WAIT;
        end
      end
      OUT_WAIT: out_state_d = OUT_IDLE;
      default:  out_state_d = OUT_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      in_state_q  <= IN_IDLE;
      out_state_q <= OUT_IDLE;
      run_q       <= 1'b0;
      read_q      <= 1'b0;
      src_valid_q <= 1'b0;
      src_l_q     <= '0;
      src_r_q     <= '0;
      drop_q      <= '0;
      wr_q        <= 1'b0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      run_q       <= 1'b1;
      read_q      <= read_d;
      src_valid_q <= src_valid_d;
      src_l_q     <= src_l_d;
      src_r_q     <= src_r_d;
      drop_q      <= drop_d;
      wr_q        <= wr_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge CLOCK_50) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {snk_L, snk_R};
  end

  assign read_audio_in           = read_q;
  assign write_audio_out         = wr_q;
  assign left_channel_audio_out  = out_l_q;
  assign right_channel_audio_out = out_r_q;
  assign src_valid               = src_valid_q;
  assign src_L                   = src_l_q;
  assign src_R                   = src_r_q;
  assign drop_count              = drop_q;
  assign snk_ready               = run_q && !fifo_full;

endmodule

// File: tb/tb_audio_stream_bridge.sv
module tb_audio_stream_bridge;

  localparam int DW = 32;

  logic          clk;
  logic          reset_n;
  logic          avail;
  logic [DW-1:0] in_l, in_r;
  logic          allowed;
  logic          tb_src_ready;
  logic          tb_snk_valid;
  logic [DW-1:0] tb_snk_l, tb_snk_r;
  logic          loop;

  logic          read_audio_in, write_audio_out;
  logic [DW-1:0] out_l, out_r;
  logic          src_valid, src_ready, snk_valid, snk_ready;
  logic [DW-1:0] src_l, src_r, snk_l, snk_r;
  logic [15:0]   drop_count;

  logic          d0_read, d0_write, d0_src_valid, d0_snk_ready;
  logic [DW-1:0] d0_out_l, d0_out_r, d0_src_l, d0_src_r;
  logic [15:0]   d0_drop;
  logic          d0_allowed, d0_snk_valid;

  assign src_ready    = loop ? snk_ready : tb_src_ready;
  assign snk_valid    = loop ? src_valid : tb_snk_valid;
  assign snk_l        = loop ? src_l     : tb_snk_l;
  assign snk_r        = loop ? src_r     : tb_snk_r;
  assign d0_allowed   = 1'b0;
  assign d0_snk_valid = 1'b0;

  audio_stream_bridge #(.DATA_W(DW), .FIFO_DEPTH(4), .DROP_WHEN_FULL(1)) dut (
    .CLOCK_50(clk), .reset_n(reset_n),
    .audio_in_available(avail), .read_audio_in(read_audio_in),
    .left_channel_audio_in(in_l), .right_channel_audio_in(in_r),
    .audio_out_allowed(allowed), .write_audio_out(write_audio_out),
    .left_channel_audio_out(out_l), .right_channel_audio_out(out_r),
    .src_valid(src_valid), .src_ready(src_ready), .src_L(src_l), .src_R(src_r),
    .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_L(snk_l), .snk_R(snk_r),
    .drop_count(drop_count)
  );

  audio_stream_bridge #(.DATA_W(DW), .FIFO_DEPTH(4), .DROP_WHEN_FULL(0)) dut0 (
    .CLOCK_50(clk), .reset_n(reset_n),
    .audio_in_available(avail), .read_audio_in(d0_read),
    .left_channel_audio_in(in_l), .right_channel_audio_in(in_r),
    .audio_out_allowed(d0_allowed), .write_audio_out(d0_write),
    .left_channel_audio_out(d0_out_l), .right_channel_audio_out(d0_out_r),
    .src_valid(d0_src_valid), .src_ready(tb_src_ready), .src_L(d0_src_l), .src_R(d0_src_r),
    .snk_valid(d0_snk_valid), .snk_ready(d0_snk_ready), .snk_L(tb_snk_l), .snk_R(tb_snk_r),
    .drop_count(d0_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every DAC write must match the oldest expected pair.
  always @(negedge clk) begin
    if (reset_n && write_audio_out) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dac_unexpected: got %h%h expected no write", out_l, out_r);
      end else begin
        check("dac_word", {out_l, out_r}, exp_q.pop_front());
      end
    end
  end

  task automatic push_word(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit expect_it);
    bit ok;
    ok = 1'b0;
    tb_snk_valid = 1'b1;
    tb_snk_l = l;
    tb_snk_r = r;
    for (int i = 0; i < 20; i++) begin
      if (snk_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("push_timeout", 64'd0, 64'd1);
    tick();
    if (expect_it) exp_q.push_back({l, r});
    tb_snk_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int i;
    for (i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
    check("drain_remaining", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : stim
    int d0_reads;
    int nw;
    int wcyc[8];
    bit acc5;
    bit acc;

    reset_n = 1'b0; avail = 1'b1; in_l = '0; in_r = '0; allowed = 1'b1;
    tb_src_ready = 1'b1; tb_snk_valid = 1'b1; tb_snk_l = 32'hDEAD0001;
    tb_snk_r = 32'hDEAD0002; loop = 1'b0;

    // 1. Reset
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_ctrl", {60'd0, read_audio_in, write_audio_out, src_valid, snk_ready}, 64'd0);
    end
    check("rst_data", {out_l, src_l}, 64'd0);
    check("rst_drop", {48'd0, drop_count}, 64'd0);
    reset_n = 1'b1; avail = 1'b0; tb_snk_valid = 1'b0; allowed = 1'b0;
    #1;
    check("snk_ready_release", {63'd0, snk_ready}, 64'd0);
    tick();
    check("snk_ready_run", {63'd0, snk_ready}, 64'd1);

    // 2. Passthrough
    loop = 1'b1; allowed = 1'b1; in_l = 32'h00123456; in_r = 32'hFFEDCBA9; avail = 1'b1;
    exp_q.push_back({32'h00123456, 32'hFFEDCBA9});
    tick();
    avail = 1'b0;
    check("pt_read", {63'd0, read_audio_in}, 64'd1);
    check("pt_src_valid", {63'd0, src_valid}, 64'd1);
    check("pt_src_data", {src_l, src_r}, {32'h00123456, 32'hFFEDCBA9});
    tick();
    check("pt_read_once", {63'd0, read_audio_in}, 64'd0);
    wait_drain(10);
    check("pt_drop", {48'd0, drop_count}, 64'd0);
    tick(); tick();

    // 3. Stall with drop (dut) and without drop (dut0)
    loop = 1'b0; allowed = 1'b0; tb_src_ready = 1'b0;
    in_l = 32'h11111111; in_r = 32'h22222222; avail = 1'b1;
    d0_reads = 0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 1) begin
        in_l = 32'h33333333; in_r = 32'h44444444;
      end
      check("stall_read_pattern", {63'd0, read_audio_in}, {63'd0, 1'(t % 2)});
      if (d0_read) d0_reads++;
    end
    avail = 1'b0;
    check("stall_hold_data", {src_l, src_r}, {32'h11111111, 32'h22222222});
    check("stall_valid", {63'd0, src_valid}, 64'd1);
    check("stall_drop3", {48'd0, drop_count}, 64'd3);
    check("nodrop_reads", 64'(d0_reads), 64'd1);
    check("nodrop_drop", {48'd0, d0_drop}, 64'd0);
    check("nodrop_hold", {d0_src_l, d0_src_r}, {32'h11111111, 32'h22222222});
    tb_src_ready = 1'b1;
    tick();
    check("stall_release", {63'd0, src_valid}, 64'd0);

    // 4. FIFO full
    for (int k = 1; k <= 4; k++) push_word(DW'(k), 32'h10000000 | DW'(k), 1'b1);
    check("full_snk_ready", {63'd0, snk_ready}, 64'd0);
    tb_snk_valid = 1'b1; tb_snk_l = 32'd5; tb_snk_r = 32'h10000005;
    tick(); tick();
    check("full_stall", {62'd0, snk_ready, write_audio_out}, 64'd0);
    allowed = 1'b1; nw = 0; acc5 = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      acc = tb_snk_valid && snk_ready;
      tick();
      if (acc) begin
        exp_q.push_back({32'd5, 32'h10000005});
        tb_snk_valid = 1'b0;
        acc5 = 1'b1;
      end
      if (write_audio_out && nw < 8) begin
        wcyc[nw] = c;
        nw++;
      end
    end
    check("full_nwrites", 64'(nw), 64'd5);
    check("full_accept5", {63'd0, acc5}, 64'd1);
    for (int i = 1; i < 5 && i < nw; i++) check("full_gap", 64'(wcyc[i] - wcyc[i-1]), 64'd2);
    wait_drain(4);
    allowed = 1'b0;

    // 5. Saturation
    tb_src_ready = 1'b0; avail = 1'b1;
    for (int t = 1; t <= 2 * 65540 + 1; t++) begin
      tick();
      if (t == 201) check("sat_partial", {48'd0, drop_count}, 64'd103);
    end
    check("sat_ffff", {48'd0, drop_count}, 64'hFFFF);
    avail = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("sat_stays", {48'd0, drop_count}, 64'hFFFF);
    check("sat_nodrop_dut0", {48'd0, d0_drop}, 64'd0);

    // 6. Mid-operation reset
    tb_src_ready = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) push_word(32'hA0 + DW'(k), 32'hB0 + DW'(k), 1'b0);
    avail = 1'b1; allowed = 1'b1;
    tick();
    check("mid_pulses_live", {62'd0, read_audio_in, write_audio_out}, 64'd3);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_pulses_cut", {62'd0, read_audio_in, write_audio_out}, 64'd0);
    check("mid_state_clear", {61'd0, src_valid, snk_ready, (drop_count != 16'd0)}, 64'd0);
    check("mid_data_clear", {out_l, src_l}, 64'd0);
    tick(); tick();
    reset_n = 1'b1; avail = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mid_fifo_empty", {63'd0, write_audio_out}, 64'd0);
    end
    push_word(32'hCAFE0001, 32'hCAFE0002, 1'b1);
    wait_drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
